// File: rtl/ycbcr422_to_rgb565_pkg.sv
// Shared widths, coefficients and helpers for the YCbCr 4:2:2 to RGB565 converter.
package ycbcr422_to_rgb565_pkg;

    localparam int PIX_W    = 8;
    localparam int D_W      = PIX_W + 1;
    localparam int SUM_W    = 18;
    localparam int FRAC_W   = 8;
    localparam int PIPE_LAT = 5;

    // Coefficients are the BT.601 inverse matrix scaled by 256
    localparam logic signed [SUM_W-1:0] K_R_CR = 18'sd359;
    localparam logic signed [SUM_W-1:0] K_G_CB = 18'sd88;
    localparam logic signed [SUM_W-1:0] K_G_CR = 18'sd183;
    localparam logic signed [SUM_W-1:0] K_B_CB = 18'sd454;

    localparam logic [PIX_W-1:0] CHROMA_OFS = 8'd128;

    typedef logic signed [SUM_W-1:0] sum_t;
    typedef logic signed [D_W-1:0]   diff_t;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    // Remove the chroma offset: 0..255 -> -128..127
    function automatic diff_t chroma_diff(input logic [PIX_W-1:0] c);
        return diff_t'({1'b0, c}) - diff_t'({1'b0, CHROMA_OFS});
    endfunction

endpackage

// File: rtl/ycbcr422_to_rgb565_if.sv
// Video stream bundle: YCbCr 4:2:2 in, RGB565 out, with frame sync signals.
interface ycbcr422_to_rgb565_if;
    import ycbcr422_to_rgb565_pkg::*;

    logic             pre_frame_vsync;
    logic             pre_frame_hsync;
    logic             pre_frame_de;
    logic [PIX_W-1:0] img_y;
    logic [PIX_W-1:0] img_c;

    logic             post_frame_vsync;
    logic             post_frame_hsync;
    logic             post_frame_de;
    logic [4:0]       img_red;
    logic [5:0]       img_green;
    logic [4:0]       img_blue;

    modport master (
        output pre_frame_vsync, pre_frame_hsync, pre_frame_de, img_y, img_c,
        input  post_frame_vsync, post_frame_hsync, post_frame_de,
        input  img_red, img_green, img_blue
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_hsync, pre_frame_de, img_y, img_c,
        output post_frame_vsync, post_frame_hsync, post_frame_de,
        output img_red, img_green, img_blue
    );

endinterface

// File: rtl/ycbcr422_to_rgb565_sat_u8.sv
// sat_u8: clamps a signed sum to the unsigned 8-bit range and registers it.
module sat_u8
    import ycbcr422_to_rgb565_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  sum_t             din,
    output logic [PIX_W-1:0] dout
);

    localparam sum_t U8_MAX = 18'sd255;

    function automatic logic [PIX_W-1:0] saturate(input sum_t v);
        if (v[SUM_W-1]) begin
            return '0;
        end else if (v > U8_MAX) begin
            return '1;
        end else begin
            return v[PIX_W-1:0];
        end
    endfunction

    // Register the clamped value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= saturate(din);
        end
    end

endmodule

// File: rtl/ycbcr422_to_rgb565.sv
// ycbcr422_to_rgb565: YCbCr 4:2:2 pixel stream to RGB565, one pixel per clock,
// five register stages, frame syncs delayed to match.
// Build macro YCBCR2RGB_ROUND_EN: round-half-up the scaled sums (default floors).
module ycbcr422_to_rgb565
    import ycbcr422_to_rgb565_pkg::*;
#(
    parameter bit CHROMA_FIRST = 1'b0,
    parameter bit OUT_BLANK    = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    ycbcr422_to_rgb565_if.slave vid
);

`ifdef YCBCR2RGB_ROUND_EN
    localparam sum_t ROUND_OFS = 18'sd128;
`else
    localparam sum_t ROUND_OFS = 18'sd0;
`endif

    function automatic sum_t scale_down(input sum_t s);
        return (s + ROUND_OFS) >>> FRAC_W;
    endfunction

    phase_e phase;

    logic [PIX_W-1:0] y_p0, c_p0;
    phase_e           ph_p0;
    logic             vld_p0;

    logic [PIX_W-1:0] pair_c, cb_sel, cr_sel, cb_hold, cr_hold;
    logic [PIX_W-1:0] y_p1, cb_p1, cr_p1;
    logic             vld_p1;

    diff_t            dcb_p1, dcr_p1;
    logic [PIX_W-1:0] y_p2;
    sum_t             prod_r_p2, prod_gb_p2, prod_gr_p2, prod_b_p2;
    logic             vld_p2;

    sum_t             ybase_p2;
    sum_t             r_p3, g_p3, b_p3;
    logic             vld_p3;

    logic [PIX_W-1:0] r_p4, g_p4, b_p4;
    logic             vld_p4;

    logic [PIPE_LAT-1:0] vsync_dly, hsync_dly;
    logic                blank;

    // Pixel phase within a line: toggles per valid pixel, restarts even on any de gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_EVEN;
        end else if (vid.pre_frame_de) begin
            phase <= (phase == PH_EVEN) ? PH_ODD : PH_EVEN;
        end else begin
            phase <= PH_EVEN;
        end
    end

    // ---- stage A: capture input pixel and its phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p0   <= '0;
            c_p0   <= '0;
            ph_p0  <= PH_EVEN;
            vld_p0 <= 1'b0;
        end else begin
            y_p0   <= vid.img_y;
            c_p0   <= vid.img_c;
            ph_p0  <= phase;
            vld_p0 <= vid.pre_frame_de;
        end
    end

    // ---- stage B: pair the two chroma samples of an even/odd pixel pair
    // Even pixel peeks at the live input for its partner sample; a line ending on
    // an even pixel has no partner, so neutral chroma stands in.
    always_comb begin
        pair_c = vid.pre_frame_de ? vid.img_c : CHROMA_OFS;
        cb_sel = cb_hold;
        cr_sel = cr_hold;
        if (ph_p0 == PH_EVEN) begin
            if (CHROMA_FIRST) begin
                cb_sel = pair_c;
                cr_sel = c_p0;
            end else begin
                cb_sel = c_p0;
                cr_sel = pair_c;
            end
        end
    end

    // Keep the even pixel's pair so the following odd pixel reuses it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb_hold <= '0;
            cr_hold <= '0;
        end else if (vld_p0 && ph_p0 == PH_EVEN) begin
            cb_hold <= cb_sel;
            cr_hold <= cr_sel;
        end
    end

    // Register luma with aligned chroma
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p1   <= '0;
            cb_p1  <= '0;
            cr_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            y_p1   <= y_p0;
            cb_p1  <= cb_sel;
            cr_p1  <= cr_sel;
            vld_p1 <= vld_p0;
        end
    end

    // ---- stage C: signed chroma products
    assign dcb_p1 = chroma_diff(cb_p1);
    assign dcr_p1 = chroma_diff(cr_p1);

    // Multiply offset-removed chroma by the scaled coefficients
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p2       <= '0;
            prod_r_p2  <= '0;
            prod_gb_p2 <= '0;
            prod_gr_p2 <= '0;
            prod_b_p2  <= '0;
            vld_p2     <= 1'b0;
        end else begin
            y_p2       <= y_p1;
            prod_r_p2  <= sum_t'(dcr_p1) * K_R_CR;
            prod_gb_p2 <= sum_t'(dcb_p1) * K_G_CB;
            prod_gr_p2 <= sum_t'(dcr_p1) * K_G_CR;
            prod_b_p2  <= sum_t'(dcb_p1) * K_B_CB;
            vld_p2     <= vld_p1;
        end
    end

    // ---- stage D: sum with scaled luma and drop the fractional bits
    assign ybase_p2 = {2'b00, y_p2, 8'h00};

    // Form the three channel sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p3   <= '0;
            g_p3   <= '0;
            b_p3   <= '0;
            vld_p3 <= 1'b0;
        end else begin
            r_p3   <= scale_down(ybase_p2 + prod_r_p2);
            g_p3   <= scale_down(ybase_p2 - prod_gb_p2 - prod_gr_p2);
            b_p3   <= scale_down(ybase_p2 + prod_b_p2);
            vld_p3 <= vld_p2;
        end
    end

    // ---- stage E: clamp to 0..255
    sat_u8 u_sat_r (.clk(clk), .rst_n(rst_n), .din(r_p3), .dout(r_p4));
    sat_u8 u_sat_g (.clk(clk), .rst_n(rst_n), .din(g_p3), .dout(g_p4));
    sat_u8 u_sat_b (.clk(clk), .rst_n(rst_n), .din(b_p3), .dout(b_p4));

    // Carry de through the last stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p4 <= 1'b0;
        end else begin
            vld_p4 <= vld_p3;
        end
    end

    // Frame syncs follow the same number of register stages as the pixel data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_dly <= '0;
            hsync_dly <= '0;
        end else begin
            vsync_dly <= {vsync_dly[PIPE_LAT-2:0], vid.pre_frame_vsync};
            hsync_dly <= {hsync_dly[PIPE_LAT-2:0], vid.pre_frame_hsync};
        end
    end

    assign vid.post_frame_vsync = vsync_dly[PIPE_LAT-1];
    assign vid.post_frame_hsync = hsync_dly[PIPE_LAT-1];
    assign vid.post_frame_de    = vld_p4;

    // Pack RGB565 and optionally blank outside active video
    always_comb begin
        blank         = OUT_BLANK && !vld_p4;
        vid.img_red   = blank ? 5'd0 : r_p4[7:3];
        vid.img_green = blank ? 6'd0 : g_p4[7:2];
        vid.img_blue  = blank ? 5'd0 : b_p4[7:3];
    end

endmodule

// File: tb/tb_ycbcr422_to_rgb565.sv
// Directed bench for ycbcr422_to_rgb565 (default parameters).
module tb_ycbcr422_to_rgb565;

    // Inputs set before clock edge k show up on the outputs right after edge k+4,
    // i.e. five clock periods after they were presented.
    localparam int LAG = 4;

    localparam logic [15:0] RGB_GRAY = 16'h8410;
    localparam logic [15:0] RGB_HOT  = 16'hFD3F;
    localparam logic [15:0] RGB_TAIL = 16'h6384;
`ifdef YCBCR2RGB_ROUND_EN
    localparam logic [15:0] RGB_DARK = 16'h0440;
    localparam logic [15:0] RGB_PAIR = 16'h03FC;
`else
    localparam logic [15:0] RGB_DARK = 16'h0420;
    localparam logic [15:0] RGB_PAIR = 16'h03DC;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    ycbcr422_to_rgb565_if vid();

    ycbcr422_to_rgb565 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vid)
    );

    always #5 clk = ~clk;

    wire [15:0] rgb = {vid.img_red, vid.img_green, vid.img_blue};

    task automatic drive(input logic vs, input logic hs, input logic de,
                         input logic [7:0] y, input logic [7:0] c);
        vid.pre_frame_vsync = vs;
        vid.pre_frame_hsync = hs;
        vid.pre_frame_de    = de;
        vid.img_y           = y;
        vid.img_c           = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd250);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vid.pre_frame_vsync = 1'b1;
        vid.pre_frame_hsync = 1'b1;
        vid.pre_frame_de    = 1'b1;
        vid.img_y           = 8'd255;
        vid.img_c           = 8'd255;
        #3;
        total++;
        if (vid.post_frame_vsync !== 1'b0) begin
            bad++;
            $display("FAIL reset_vsync: got %b want 0", vid.post_frame_vsync);
        end
        total++;
        if (vid.post_frame_hsync !== 1'b0) begin
            bad++;
            $display("FAIL reset_hsync: got %b want 0", vid.post_frame_hsync);
        end
        total++;
        if (vid.post_frame_de !== 1'b0) begin
            bad++;
            $display("FAIL reset_de: got %b want 0", vid.post_frame_de);
        end
        total++;
        if (rgb !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rgb: got %h want 0000", rgb);
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if ({vid.post_frame_vsync, vid.post_frame_hsync, vid.post_frame_de} !== 3'b000 || rgb !== 16'h0000) begin
            bad++;
            $display("FAIL reset_held: syncs=%b rgb=%h want 000 0000",
                     {vid.post_frame_vsync, vid.post_frame_hsync, vid.post_frame_de}, rgb);
        end
        rst_n = 1'b1;
        repeat (6) idle();
    endtask

    task automatic test_gray();
        for (int k = 0; k < 8 + LAG; k++) begin
            if (k < 8) drive(1'b0, 1'b0, 1'b1, 8'd128, 8'd128);
            else idle();
            if (k >= LAG) begin
                total++;
                if (vid.post_frame_de !== 1'b1 || rgb !== RGB_GRAY) begin
                    bad++;
                    $display("FAIL gray[%0d]: de=%b rgb=%h want de=1 rgb=%h", k - LAG, vid.post_frame_de, rgb, RGB_GRAY);
                end
            end
        end
        idle();
        total++;
        if (vid.post_frame_de !== 1'b0 || rgb !== 16'h0000) begin
            bad++;
            $display("FAIL gray_after: de=%b rgb=%h want de=0 rgb=0000", vid.post_frame_de, rgb);
        end
        repeat (2) idle();
    endtask

    task automatic test_hot();
        for (int k = 0; k < 4 + LAG; k++) begin
            if (k < 4) drive(1'b0, 1'b0, 1'b1, 8'd255, (k % 2 == 0) ? 8'd128 : 8'd255);
            else idle();
            if (k >= LAG) begin
                total++;
                if (vid.post_frame_de !== 1'b1 || rgb !== RGB_HOT) begin
                    bad++;
                    $display("FAIL hot[%0d]: de=%b rgb=%h want de=1 rgb=%h", k - LAG, vid.post_frame_de, rgb, RGB_HOT);
                end
            end
        end
        repeat (2) idle();
    endtask

    task automatic test_dark();
        logic [15:0] want;
        for (int k = 0; k < 8 + LAG; k++) begin
            if (k < 8) drive(1'b0, 1'b0, 1'b1, 8'd0, (k < 4) ? 8'd0 : 8'd128);
            else idle();
            if (k >= LAG) begin
                want = (k - LAG < 4) ? RGB_DARK : 16'h0000;
                total++;
                if (vid.post_frame_de !== 1'b1 || rgb !== want) begin
                    bad++;
                    $display("FAIL dark[%0d]: de=%b rgb=%h want de=1 rgb=%h", k - LAG, vid.post_frame_de, rgb, want);
                end
            end
        end
        repeat (2) idle();
    endtask

    task automatic test_odd_line();
        logic [7:0]  cv   [3];
        logic [15:0] want [3];
        cv[0] = 8'd200;  cv[1] = 8'd60;   cv[2] = 8'd90;
        want[0] = RGB_PAIR; want[1] = RGB_PAIR; want[2] = RGB_TAIL;
        for (int k = 0; k < 3 + LAG; k++) begin
            if (k < 3) drive(1'b0, 1'b0, 1'b1, 8'd100, cv[k]);
            else idle();
            if (k >= LAG) begin
                total++;
                if (vid.post_frame_de !== 1'b1 || rgb !== want[k - LAG]) begin
                    bad++;
                    $display("FAIL odd_line[%0d]: de=%b rgb=%h want de=1 rgb=%h",
                             k - LAG, vid.post_frame_de, rgb, want[k - LAG]);
                end
            end
        end
        repeat (2) idle();
    endtask

    task automatic test_sync();
        logic [15:0] vsp, hsp, dep;
        logic [15:0] want;
        vsp = 16'b0000_0000_0000_0111;
        hsp = 16'b0001_1000_0110_0001;
        dep = 16'b1110_0111_1001_1100;
        for (int k = 0; k < 16 + LAG; k++) begin
            if (k < 16) drive(vsp[k], hsp[k], dep[k], 8'd128, 8'd128);
            else idle();
            if (k >= LAG) begin
                want = dep[k - LAG] ? RGB_GRAY : 16'h0000;
                total++;
                if (vid.post_frame_vsync !== vsp[k - LAG] || vid.post_frame_hsync !== hsp[k - LAG] ||
                    vid.post_frame_de !== dep[k - LAG] || rgb !== want) begin
                    bad++;
                    $display("FAIL sync[%0d]: vs/hs/de=%b%b%b rgb=%h want %b%b%b rgb=%h", k - LAG,
                             vid.post_frame_vsync, vid.post_frame_hsync, vid.post_frame_de, rgb,
                             vsp[k - LAG], hsp[k - LAG], dep[k - LAG], want);
                end
            end
        end
        repeat (2) idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b0, 1'b1, 8'd255, (k % 2 == 0) ? 8'd128 : 8'd255);
        end
        total++;
        if (vid.post_frame_vsync !== 1'b1 || vid.post_frame_de !== 1'b1 || rgb !== RGB_HOT) begin
            bad++;
            $display("FAIL mid_before: vs=%b de=%b rgb=%h want vs=1 de=1 rgb=%h",
                     vid.post_frame_vsync, vid.post_frame_de, rgb, RGB_HOT);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({vid.post_frame_vsync, vid.post_frame_hsync, vid.post_frame_de} !== 3'b000 || rgb !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset: syncs=%b rgb=%h want 000 0000",
                     {vid.post_frame_vsync, vid.post_frame_hsync, vid.post_frame_de}, rgb);
        end
        drive(1'b1, 1'b0, 1'b1, 8'd255, 8'd255);
        drive(1'b1, 1'b0, 1'b1, 8'd255, 8'd128);
        rst_n = 1'b1;
        for (int k = 0; k < 2 + LAG; k++) begin
            if (k < 2) drive(1'b0, 1'b0, 1'b1, 8'd255, (k == 0) ? 8'd128 : 8'd255);
            else idle();
            if (k < LAG) begin
                total++;
                if (vid.post_frame_de !== 1'b0 || vid.post_frame_vsync !== 1'b0 || rgb !== 16'h0000) begin
                    bad++;
                    $display("FAIL mid_flush[%0d]: vs=%b de=%b rgb=%h want 0 0 0000",
                             k, vid.post_frame_vsync, vid.post_frame_de, rgb);
                end
            end else begin
                total++;
                if (vid.post_frame_de !== 1'b1 || rgb !== RGB_HOT) begin
                    bad++;
                    $display("FAIL mid_restart[%0d]: de=%b rgb=%h want de=1 rgb=%h",
                             k - LAG, vid.post_frame_de, rgb, RGB_HOT);
                end
            end
        end
        repeat (2) idle();
    endtask

    initial begin
        test_reset();
        test_gray();
        test_hot();
        test_dark();
        test_odd_line();
        test_sync();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
